// File: rtl/uart_frame_assembler_pkg.sv
// uart_frame_assembler_pkg: shared frame sizing constants and FSM state encoding
package uart_frame_assembler_pkg;
  localparam int N_SAMPLES_DEF   = 16;
  localparam int SAMPLE_W_DEF    = 16;
  localparam int CLOCK_PER_BIT   = 434;
  localparam int GAP_TIMEOUT_DEF = 10 * 10 * CLOCK_PER_BIT;
  typedef enum logic {FILL, DRAIN} state_e;
endpackage

// File: rtl/uart_frame_buffer.sv
// uart_frame_buffer: one-frame sample store, single write port and asynchronous read
module uart_frame_buffer #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem_q [DEPTH];
  // storage has no reset: a frame is always fully rewritten before it is drained
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler: packs UART bytes into 16-bit samples and streams one frame to the FFT
module uart_frame_assembler
  import uart_frame_assembler_pkg::*;
#(
  parameter int N_SAMPLES   = N_SAMPLES_DEF,
  parameter int SAMPLE_W    = SAMPLE_W_DEF,
  parameter int GAP_TIMEOUT = GAP_TIMEOUT_DEF,
  parameter int IDX_W       = $clog2(N_SAMPLES)
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic [7:0]          i_rx_byte,
  input  logic                i_rx_valid,
  input  logic                i_rx_error,
  output logic [SAMPLE_W-1:0] o_sample,
  output logic [IDX_W-1:0]    o_sample_idx,
  output logic                o_sample_valid,
  input  logic                i_sample_ready,
  output logic                o_frame_last,
  output logic                o_busy,
  output logic                o_overrun,
  output logic                o_resync
);
  localparam int GAP_W = $clog2(GAP_TIMEOUT);
  localparam logic [IDX_W:0]   LAST_BYTE = (IDX_W+1)'(2*N_SAMPLES-1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(N_SAMPLES-1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_TIMEOUT-1);
  state_e              state_q;
  logic [IDX_W:0]      byte_cnt_q;
  logic [GAP_W-1:0]    gap_cnt_q;
  logic [IDX_W-1:0]    rd_idx_q;
  logic [7:0]          lo_q;
  logic                overrun_q;
  logic                resync_q;
  logic                fill;
  logic                we;
  logic [SAMPLE_W-1:0] rdata;
  assign fill = state_q == FILL;
  assign we   = fill && i_rx_valid && !i_rx_error && byte_cnt_q[0];
  uart_frame_buffer #(.DEPTH(N_SAMPLES), .W(SAMPLE_W), .AW(IDX_W)) u_buf (
    .clk     (i_clk),
    .we_i    (we),
    .waddr_i (byte_cnt_q[IDX_W:1]),
    .wdata_i ({i_rx_byte, lo_q}),
    .raddr_i (rd_idx_q),
    .rdata_o (rdata)
  );
  // fill/drain FSM with byte and gap counters; an error or an expired gap drops the partial frame
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= FILL;
      byte_cnt_q <= '0;
      gap_cnt_q  <= '0;
      rd_idx_q   <= '0;
      lo_q       <= '0;
      overrun_q  <= 1'b0;
      resync_q   <= 1'b0;
    end else begin
      overrun_q <= !fill && i_rx_valid;
      resync_q  <= 1'b0;
      if (fill) begin
        if (i_rx_error) begin
          byte_cnt_q <= '0;
          gap_cnt_q  <= '0;
          resync_q   <= 1'b1;
        end else if (i_rx_valid) begin
          gap_cnt_q <= '0;
          if (!byte_cnt_q[0]) lo_q <= i_rx_byte;
          byte_cnt_q <= byte_cnt_q == LAST_BYTE ? '0 : byte_cnt_q + 1'b1;
          if (byte_cnt_q == LAST_BYTE) state_q <= DRAIN;
        end else if (byte_cnt_q != '0) begin
          byte_cnt_q <= gap_cnt_q == GAP_LAST ? '0 : byte_cnt_q;
          gap_cnt_q  <= gap_cnt_q == GAP_LAST ? '0 : gap_cnt_q + 1'b1;
          resync_q   <= gap_cnt_q == GAP_LAST;
        end
      end else if (i_sample_ready) begin
        rd_idx_q <= rd_idx_q == LAST_IDX ? '0 : rd_idx_q + 1'b1;
        if (rd_idx_q == LAST_IDX) state_q <= FILL;
      end
    end
  end
  assign o_sample       = fill ? '0 : rdata;
  assign o_sample_idx   = rd_idx_q;
  assign o_sample_valid = !fill;
  assign o_busy         = !fill;
  assign o_frame_last   = !fill && rd_idx_q == LAST_IDX;
  assign o_overrun      = overrun_q;
  assign o_resync       = resync_q;
endmodule

// File: tb/tb_uart_frame_assembler.sv
// tb_uart_frame_assembler: directed and random stimulus against a byte-queue reference model
module tb_uart_frame_assembler;
  localparam int N   = 16;
  localparam int GAP = 40;
  logic        clk = 1'b0;
  logic        rst, rx_valid, rx_error, ready;
  logic [7:0]  rx_byte;
  logic [15:0] sample;
  logic [3:0]  idx;
  logic        sv, last, busy, ovr, rsy;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          rdy_mode = 0;
  bit          rdy_t = 1'b0;
  bit          m_drain, m_ovr, m_rsy;
  logic [7:0]  q[$];
  int          m_idle, m_rd;
  logic [15:0] m_frame[N];
  always #5 clk = ~clk;
  uart_frame_assembler #(.N_SAMPLES(N), .SAMPLE_W(16), .GAP_TIMEOUT(GAP), .IDX_W(4)) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_rx_byte      (rx_byte),
    .i_rx_valid     (rx_valid),
    .i_rx_error     (rx_error),
    .o_sample       (sample),
    .o_sample_idx   (idx),
    .o_sample_valid (sv),
    .i_sample_ready (ready),
    .o_frame_last   (last),
    .o_busy         (busy),
    .o_overrun      (ovr),
    .o_resync       (rsy)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(input logic v, input logic [7:0] b, input logic e, input logic r, input logic rs);
    if (rs) begin
      m_drain = 0; q.delete(); m_idle = 0; m_rd = 0; m_ovr = 0; m_rsy = 0;
      return;
    end
    m_ovr = m_drain && v;
    m_rsy = 0;
    if (!m_drain) begin
      if (e) begin
        q.delete(); m_idle = 0; m_rsy = 1;
      end else if (v) begin
        q.push_back(b);
        m_idle = 0;
        if (q.size() == 2*N) begin
          for (int k = 0; k < N; k++) m_frame[k] = {q[2*k+1], q[2*k]};
          q.delete();
          m_drain = 1;
          m_rd = 0;
        end
      end else if (q.size() != 0) begin
        m_idle++;
        if (m_idle == GAP) begin
          q.delete(); m_idle = 0; m_rsy = 1;
        end
      end
    end else if (r) begin
      if (m_rd == N-1) m_drain = 0;
      m_rd = (m_rd + 1) % N;
    end
  endtask
  task automatic check_outputs();
    chk("valid",   32'(sv),     32'(m_drain));
    chk("busy",    32'(busy),   32'(m_drain));
    chk("idx",     32'(idx),    32'(m_rd));
    chk("sample",  32'(sample), m_drain ? 32'(m_frame[m_rd]) : 32'h0);
    chk("last",    32'(last),   32'(m_drain && m_rd == N-1));
    chk("overrun", 32'(ovr),    32'(m_ovr));
    chk("resync",  32'(rsy),    32'(m_rsy));
  endtask
  task automatic step(input logic v, input logic [7:0] b, input logic e, input logic rs);
    if (rdy_mode == 1) rdy_t = ~rdy_t;
    rx_valid = v; rx_byte = b; rx_error = e; rst = rs;
    ready = rdy_mode == 0 ? 1'b1 : rdy_mode == 1 ? rdy_t : rdy_mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
    @(posedge clk);
    model(v, b, e, ready, rs);
    @(negedge clk);
    check_outputs();
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 8'h00, 0, 0);
  endtask
  task automatic send_pattern();
    for (int k = 0; k < N; k++) begin
      step(1, 8'(8'hA0 + k), 0, 0);
      step(1, 8'(k), 0, 0);
    end
  endtask
  task automatic send_rand(input int n);
    for (int i = 0; i < n; i++) step(1, 8'($urandom), 0, 0);
  endtask
  initial begin
    int r;
    rst = 1; rx_valid = 0; rx_error = 0; rx_byte = 0; ready = 0;
    @(negedge clk);
    step(0, 8'h00, 0, 1);
    step(0, 8'h00, 0, 1);
    rdy_mode = 0; send_pattern(); idle(N + 4);
    rdy_mode = 1; send_pattern(); idle(2*N + 6);
    rdy_mode = 0; send_rand(5); step(0, 8'h00, 1, 0); send_pattern(); idle(N + 4);
    send_rand(2); step(1, 8'h55, 1, 0); send_rand(2*N); idle(N + 4);
    send_rand(3); idle(GAP + 3); send_pattern(); idle(N + 4);
    send_rand(3); idle(GAP - 1); send_rand(1); idle(GAP - 1); send_rand(2*N - 4); idle(N + 4);
    rdy_mode = 3; send_pattern(); idle(2);
    step(1, 8'h11, 0, 0); idle(1); step(1, 8'h22, 0, 0); idle(3);
    rdy_mode = 0; idle(N + 2); send_pattern(); idle(N + 4);
    send_pattern();
    for (int i = 0; i < 2*N && !(sv && idx == 4'd7); i++) idle(1);
    chk("reach_idx7", 32'({sv, idx}), 32'h17);
    step(0, 8'h00, 0, 1);
    send_pattern(); idle(N + 4);
    rdy_mode = 2;
    for (int i = 0; i < 4000; i++) begin
      r = $urandom_range(0, 199);
      if (r < 90) step(1, 8'($urandom), 0, 0);
      else if (r < 93) step(0, 8'h00, 1, 0);
      else if (r < 95) step(1, 8'($urandom), 1, 0);
      else if (r < 96) step(0, 8'h00, 0, 1);
      else if (r < 98) idle(GAP);
      else idle(1);
    end
    rdy_mode = 0; idle(2*N);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
